// File: rtl/dvp_pkg.sv
// Shared DVP-path constants: divider operand widths, centroid fixed-point
// scaling, and the operand width check used by the centroid accumulator.
package dvp_pkg;
    localparam int unsigned DIV_DW        = 26;
    localparam int unsigned DIV_VW        = 26;
    localparam int unsigned CENTROID_FRAC = 4;

    // Both operands must keep their MSB clear so the signed divider sees them as non-negative.
    function automatic bit widths_ok(input int unsigned ww, input int unsigned xw,
                                     input int unsigned frac, input int unsigned dw,
                                     input int unsigned vw);
        return ((ww + 2 * xw + frac) < dw) && ((ww + xw) < vw);
    endfunction
endpackage

// File: rtl/seg_centroid_mac.sv
// Multiply-add and accumulator pair for one segment's sum of w and sum of w*x.
module seg_mac #(
    parameter int unsigned WW = 8,
    parameter int unsigned XW = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  first,
    input  logic [WW-1:0]         wgt,
    input  logic [XW-1:0]         x,
    output logic [WW+XW-1:0]      sum_w_c,
    output logic [WW+2*XW-1:0]    sum_wx_c
);
    localparam int unsigned AW  = WW + XW;
    localparam int unsigned AXW = WW + 2 * XW;

    logic [AW-1:0]  acc_w;
    logic [AXW-1:0] acc_wx;
    logic [AW-1:0]  prod;

    // The first pixel of a segment replaces the sums instead of adding to them.
    always_comb begin
        prod     = AW'(wgt) * AW'(x);
        sum_w_c  = (first ? '0 : acc_w) + AW'(wgt);
        sum_wx_c = (first ? '0 : acc_wx) + AXW'(prod);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_w  <= '0;
            acc_wx <= '0;
        end else if (en) begin
            acc_w  <= sum_w_c;
            acc_wx <= sum_wx_c;
        end
    end
endmodule

// File: rtl/seg_centroid.sv
// Streaming per-segment weighted-centroid accumulator; emits one dividend/divisor
// pair per completed segment for the downstream pipelined divider.
module seg_centroid
    import dvp_pkg::*;
#(
    parameter int unsigned WW   = 8,
    parameter int unsigned SEG  = 16,
    parameter int unsigned FRAC = CENTROID_FRAC,
    parameter int unsigned DW   = DIV_DW,
    parameter int unsigned VW   = DIV_VW,
    parameter int unsigned SW   = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cke,
    input  logic          vin,
    input  logic          sol,
    input  logic [WW-1:0] wgt,
    output logic [DW-1:0] dividend,
    output logic [VW-1:0] divisor,
    output logic          zero,
    output logic [SW-1:0] seg_idx,
    output logic          vout
);
    localparam int unsigned XW  = $clog2(SEG);
    localparam int unsigned AW  = WW + XW;
    localparam int unsigned AXW = WW + 2 * XW;

    if (SEG < 2 || (SEG & (SEG - 1)) != 0) begin : g_bad_seg
        $error("seg_centroid: SEG must be a power of two >= 2");
    end
    if (!widths_ok(WW, XW, FRAC, DW, VW)) begin : g_bad_widths
        $error("seg_centroid: divider operand widths too narrow");
    end

    logic [XW-1:0]  x_cnt;
    logic [XW-1:0]  x_cur;
    logic [SW-1:0]  seg_cnt;
    logic [SW-1:0]  seg_cur;
    logic           accept;
    logic           seg_end;
    logic           sw_zero;
    logic [AW-1:0]  sum_w;
    logic [AXW-1:0] sum_wx;

    // sol forces the pixel to x=0 of segment 0, dropping any partial segment.
    always_comb begin
        accept  = cke & vin;
        x_cur   = sol ? '0 : x_cnt;
        seg_cur = sol ? '0 : seg_cnt;
        seg_end = accept && (x_cur == XW'(SEG - 1));
        sw_zero = (sum_w == '0);
    end

    seg_mac #(
        .WW (WW),
        .XW (XW)
    ) u_mac (
        .clk      (clk),
        .rst      (rst),
        .en       (accept),
        .first    (x_cur == '0),
        .wgt      (wgt),
        .x        (x_cur),
        .sum_w_c  (sum_w),
        .sum_wx_c (sum_wx)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_cnt   <= '0;
            seg_cnt <= '0;
        end else if (accept) begin
            x_cnt   <= x_cur + XW'(1);
            seg_cnt <= seg_end ? seg_cur + SW'(1) : seg_cur;
        end
    end

    // Data registers hold between strobes; a zero-weight segment gets divisor 1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vout     <= 1'b0;
            zero     <= 1'b0;
            dividend <= '0;
            divisor  <= '0;
            seg_idx  <= '0;
        end else if (cke) begin
            vout <= seg_end;
            if (seg_end) begin
                zero     <= sw_zero;
                divisor  <= sw_zero ? VW'(1) : VW'(sum_w);
                dividend <= sw_zero ? '0 : (DW'(sum_wx) << FRAC);
                seg_idx  <= seg_cur;
            end
        end
    end
endmodule

// File: tb/tb_seg_centroid.sv
// Scoreboard bench: two instances (SEG=4, SEG=16) share one randomized pixel
// stream; a segment-buffer model predicts results, a monitor pops and compares.
module tb_seg_centroid;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cke = 1'b0;
    logic        vin = 1'b0;
    logic        sol = 1'b0;
    logic [7:0]  wgt = 8'd0;

    logic [25:0] dvd4, dvs4, dvd16, dvs16;
    logic        z4, z16, vo4, vo16;
    logic [7:0]  idx4, idx16;

    typedef struct packed {
        logic [25:0] dvd;
        logic [25:0] dvs;
        logic        z;
        logic [7:0]  idx;
    } res_t;

    res_t q4[$];
    res_t q16[$];
    int   buf4[$];
    int   buf16[$];
    int   idx_m[2];
    res_t last_res[2];
    bit   prev_en_v[2];
    bit   prev_v[2];
    logic last_cke = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    seg_centroid #(.SEG(4)) u4 (
        .clk(clk), .rst(rst), .cke(cke), .vin(vin), .sol(sol), .wgt(wgt),
        .dividend(dvd4), .divisor(dvs4), .zero(z4), .seg_idx(idx4), .vout(vo4)
    );

    seg_centroid #(.SEG(16)) u16 (
        .clk(clk), .rst(rst), .cke(cke), .vin(vin), .sol(sol), .wgt(wgt),
        .dividend(dvd16), .divisor(dvs16), .zero(z16), .seg_idx(idx16), .vout(vo16)
    );

    // Reference: collect a segment's weights, then compute sums directly.
    task automatic model_seg(input int d, input bit s, input int w);
        int   n;
        int   sz;
        int   sw;
        int   swx;
        res_t r;
        n = (d == 0) ? 4 : 16;
        if (s) begin
            if (d == 0) buf4.delete(); else buf16.delete();
            idx_m[d] = 0;
        end
        if (d == 0) buf4.push_back(w); else buf16.push_back(w);
        sz = (d == 0) ? buf4.size() : buf16.size();
        if (sz == n) begin
            sw  = 0;
            swx = 0;
            for (int i = 0; i < n; i++) begin
                int wi;
                wi = (d == 0) ? buf4[i] : buf16[i];
                sw  += wi;
                swx += wi * i;
            end
            r.z   = (sw == 0);
            r.dvs = r.z ? 26'd1 : 26'(sw);
            r.dvd = r.z ? 26'd0 : 26'(swx * 16);
            r.idx = 8'(idx_m[d]);
            if (d == 0) begin q4.push_back(r); buf4.delete(); end
            else begin q16.push_back(r); buf16.delete(); end
            idx_m[d] = (idx_m[d] + 1) % 256;
        end
    endtask

    task automatic pix(input bit c, input bit v, input bit s, input int w);
        @(posedge clk);
        #1;
        cke = c;
        vin = v;
        sol = s;
        wgt = 8'(w);
        if (c && v) begin
            model_seg(0, s, w);
            model_seg(1, s, w);
        end
    endtask

    task automatic check_zero(input string nm);
        checks++;
        if ({vo4, z4, dvd4, dvs4, idx4} !== '0) begin
            failures++;
            $display("FAIL %s seg4: vout=%b zero=%b dividend=%0d divisor=%0d seg_idx=%0d, required all 0",
                     nm, vo4, z4, dvd4, dvs4, idx4);
        end
        checks++;
        if ({vo16, z16, dvd16, dvs16, idx16} !== '0) begin
            failures++;
            $display("FAIL %s seg16: vout=%b zero=%b dividend=%0d divisor=%0d seg_idx=%0d, required all 0",
                     nm, vo16, z16, dvd16, dvs16, idx16);
        end
    endtask

    task automatic mon(input int d, input logic v, input logic [25:0] a, input logic [25:0] b,
                       input logic z, input logic [7:0] i);
        res_t got;
        res_t e;
        int   qs;
        got = {a, b, z, i};
        if (rst) begin
            prev_v[d]    = 1'b0;
            prev_en_v[d] = 1'b0;
            return;
        end
        if (last_cke) begin
            if (v === 1'b1) begin
                checks++;
                if (prev_en_v[d]) begin
                    failures++;
                    $display("FAIL vout_width dut=%0d: vout high for 2 enabled cycles, required 1", d);
                end
                checks++;
                qs = (d == 0) ? q4.size() : q16.size();
                if (qs == 0) begin
                    failures++;
                    $display("FAIL unexpected_vout dut=%0d: got dividend=%0d divisor=%0d zero=%b seg_idx=%0d, required no strobe",
                             d, a, b, z, i);
                end else begin
                    e = (d == 0) ? q4.pop_front() : q16.pop_front();
                    if (got !== e) begin
                        failures++;
                        $display("FAIL result dut=%0d: got dividend=%0d divisor=%0d zero=%b seg_idx=%0d, required dividend=%0d divisor=%0d zero=%b seg_idx=%0d",
                                 d, a, b, z, i, e.dvd, e.dvs, e.z, e.idx);
                    end
                end
                last_res[d] = got;
            end
            prev_en_v[d] = (v === 1'b1);
        end else begin
            checks++;
            if ((v !== prev_v[d]) || (v === 1'b1 && got !== last_res[d])) begin
                failures++;
                $display("FAIL hold dut=%0d: vout=%b data changed or strobe moved with cke low, required vout=%b and held data",
                         d, v, prev_v[d]);
            end
        end
        prev_v[d] = (v === 1'b1);
    endtask

    always @(posedge clk) last_cke <= cke;

    always @(negedge clk) begin
        mon(0, vo4, dvd4, dvs4, z4, idx4);
        mon(1, vo16, dvd16, dvs16, z16, idx16);
    end

    initial begin
        bit c;
        bit v;
        bit s;
        int k;
        int guard;

        #1;
        check_zero("reset_state");
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;

        // Worked example: 0,0,10,10 -> 800/20 on the SEG=4 instance.
        pix(1, 1, 1, 0); pix(1, 1, 0, 0); pix(1, 1, 0, 10); pix(1, 1, 0, 10);

        // Saturated line: two SEG=16 segments of 255.
        pix(1, 1, 1, 255);
        repeat (31) pix(1, 1, 0, 255);

        // All-zero segment.
        pix(1, 1, 1, 0);
        repeat (15) pix(1, 1, 0, 0);

        // sol on what would be x=SEG-1 aborts the segment.
        pix(1, 1, 1, 5); pix(1, 1, 0, 6); pix(1, 1, 0, 7); pix(1, 1, 1, 8);
        repeat (3) pix(1, 1, 0, 9);

        // Random vin gaps, cke stalls and occasional sol.
        k = 0;
        guard = 0;
        while (k < 128 && guard < 5000) begin
            c = ($urandom_range(0, 3) != 0);
            v = ($urandom_range(0, 2) != 0);
            s = (k == 0) || ($urandom_range(0, 49) == 0);
            pix(c, v, s, ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(0, 255)));
            if (c && v) k++;
            guard++;
        end

        // Long line: segment index wraps on the SEG=4 instance.
        pix(1, 1, 1, int'($urandom_range(0, 255)));
        repeat (1031) pix(1, 1, 0, int'($urandom_range(0, 255)));

        // Reset while SEG=4 strobes and SEG=16 is mid-segment.
        pix(1, 1, 1, int'($urandom_range(0, 255)));
        repeat (11) pix(1, 1, 0, int'($urandom_range(0, 255)));
        pix(1, 0, 0, 0);
        @(negedge clk);
        #1;
        checks++;
        if (vo4 !== 1'b1) begin
            failures++;
            $display("FAIL pre_reset_vout: got %b, required 1", vo4);
        end
        rst = 1'b1;
        q4.delete(); q16.delete(); buf4.delete(); buf16.delete();
        idx_m[0] = 0;
        idx_m[1] = 0;
        #1;
        check_zero("mid_reset");
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;

        // No sol: first accepted pixel after reset is x=0.
        repeat (16) pix(1, 1, 0, int'($urandom_range(0, 255)));
        repeat (4) pix(1, 0, 0, 0);
        @(negedge clk);
        #1;

        checks++;
        if (q4.size() != 0) begin
            failures++;
            $display("FAIL pending_seg4: %0d results never strobed, required 0", q4.size());
        end
        checks++;
        if (q16.size() != 0) begin
            failures++;
            $display("FAIL pending_seg16: %0d results never strobed, required 0", q16.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
